// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter and its producers.
// FIFO entry layout is {dest, result}; the special flag is consumed by the write rule at enqueue.
package writeback_arbiter_pkg;

  localparam logic TRUE   = 1'b1;
  localparam logic FALSE  = 1'b0;
  localparam int   X0_IDX = 0;

  // x0 is only writable as the special register; ordinary writes to x0 are discarded.
  function automatic logic wb_write_qualify(input logic is_special, input logic dest_is_x0);
    return (is_special && dest_is_x0) || (!is_special && !dest_is_x0);
  endfunction

  function automatic int wb_entry_w(input int reg_aw, input int data_w);
    return reg_aw + data_w;
  endfunction

endpackage

// File: rtl/writeback_arbiter_wb_channel_fifo.sv
// Per-channel result FIFO: power-of-two depth, registered occupancy, synchronous flush.
module wb_channel_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign dout_o  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter: NUM_CH buffered producer channels onto regfile write port D.
// Optional decode bypass outputs are enabled by defining WB_BYPASS_EN.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        ch_is_dest_special,
  input  logic [NUM_CH*REG_AW-1:0] ch_dest_register,
  input  logic [NUM_CH*DATA_W-1:0] ch_result,
`ifdef WB_BYPASS_EN
  output logic                     bypass_valid,
  output logic [REG_AW-1:0]        bypass_key,
  output logic [DATA_W-1:0]        bypass_value,
`endif
  output logic                     portD_enable,
  output logic [REG_AW-1:0]        portD_key,
  output logic [DATA_W-1:0]        portD_value
);

  localparam int ENTRY_W = wb_entry_w(REG_AW, DATA_W);
  localparam int RR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]  full;
  logic [NUM_CH-1:0]  empty;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;
  logic [ENTRY_W-1:0] head [NUM_CH];

  logic               grant;
  logic [RR_W-1:0]    gidx;
  logic [RR_W-1:0]    cidx;
  logic [RR_W-1:0]    rr_q, rr_d;
  logic               en_q;
  logic [REG_AW-1:0]  key_q;
  logic [DATA_W-1:0]  val_q;

  // Non-qualifying results still complete the handshake; they are just never stored.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [REG_AW-1:0] dest;
    assign dest    = ch_dest_register[i*REG_AW +: REG_AW];
    assign push[i] = ch_valid[i] && !full[i] &&
                     wb_write_qualify(ch_is_dest_special[i], dest == REG_AW'(X0_IDX));

    wb_channel_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ({dest, ch_result[i*DATA_W +: DATA_W]}),
      .dout_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  assign ch_ready = ~full;

  always_comb begin
    grant = FALSE;
    gidx  = '0;
    cidx  = '0;
    pop   = '0;
    rr_d  = rr_q;
    if (enable && !flush) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cidx = RR_W'((int'(rr_q) + k) % NUM_CH);
        if (!grant && !empty[cidx]) begin
          grant = TRUE;
          gidx  = cidx;
        end
      end
    end
    if (grant) begin
      pop[gidx] = TRUE;
      rr_d      = (int'(gidx) == NUM_CH - 1) ? '0 : gidx + RR_W'(1);
    end
    if (flush) rr_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q  <= '0;
      en_q  <= FALSE;
      key_q <= '0;
      val_q <= '0;
    end else begin
      rr_q <= rr_d;
      en_q <= grant;
      if (grant) {key_q, val_q} <= head[gidx];
    end
  end

  assign portD_enable = en_q;
  assign portD_key    = key_q;
  assign portD_value  = val_q;

`ifdef WB_BYPASS_EN
  // Same entry the regfile commits on the next edge, visible to decode this cycle.
  assign bypass_valid = grant;
  assign {bypass_key, bypass_value} = head[gidx];
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: per-channel expected queues feed a port-D monitor.
module tb_writeback_arbiter;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int W      = REG_AW + DATA_W;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     enable = 1'b0;
  logic                     flush = 1'b0;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_is_dest_special = '0;
  logic [NUM_CH*REG_AW-1:0] ch_dest_register = '0;
  logic [NUM_CH*DATA_W-1:0] ch_result = '0;
  logic                     portD_enable;
  logic [REG_AW-1:0]        portD_key;
  logic [DATA_W-1:0]        portD_value;
`ifdef WB_BYPASS_EN
  logic                     bypass_valid;
  logic [REG_AW-1:0]        bypass_key;
  logic [DATA_W-1:0]        bypass_value;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int mrr = 0;
  logic [1:0] last_acc;

  writeback_arbiter #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .flush              (flush),
    .ch_valid           (ch_valid),
    .ch_ready           (ch_ready),
    .ch_is_dest_special (ch_is_dest_special),
    .ch_dest_register   (ch_dest_register),
    .ch_result          (ch_result),
`ifdef WB_BYPASS_EN
    .bypass_valid       (bypass_valid),
    .bypass_key         (bypass_key),
    .bypass_value       (bypass_value),
`endif
    .portD_enable       (portD_enable),
    .portD_key          (portD_key),
    .portD_value        (portD_value)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic qual(input logic sp, input logic [REG_AW-1:0] d);
    return (sp && d == 0) || (!sp && d != 0);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    int c;
    logic [W-1:0] e;
    if (reset && portD_enable) begin
      vectors++;
      if (exp_q0.size() == 0 && exp_q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got key=%0d value=%h, required no write", portD_key, portD_value);
      end else begin
        c = mrr;
        if (c == 0 && exp_q0.size() == 0) c = 1;
        else if (c == 1 && exp_q1.size() == 0) c = 0;
        e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if ({portD_key, portD_value} !== e) begin
          errors++;
          $display("FAIL write_data: got key=%0d value=%h, required key=%0d value=%h (ch%0d)",
                   portD_key, portD_value, e[W-1:DATA_W], e[DATA_W-1:0], c);
        end
        mrr = 1 - c;
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic         byp_v_prev;
  logic [W-1:0] byp_prev;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_v_prev <= 1'b0;
    end else begin
      byp_v_prev <= bypass_valid;
      byp_prev   <= {bypass_key, bypass_value};
    end
  end
  always @(negedge clk) begin
    if (reset && byp_v_prev) begin
      vectors++;
      if (portD_enable !== 1'b1 || {portD_key, portD_value} !== byp_prev) begin
        errors++;
        $display("FAIL bypass_match: got en=%b key=%0d value=%h, required en=1 key=%0d value=%h",
                 portD_enable, portD_key, portD_value, byp_prev[W-1:DATA_W], byp_prev[DATA_W-1:0]);
      end
    end
  end
`endif

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    mrr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ch_valid = '0;
    enable   = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    clear_model();
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic drive(input logic [1:0] v, input logic [1:0] sp,
                       input logic [REG_AW-1:0] d0, input logic [REG_AW-1:0] d1,
                       input logic [DATA_W-1:0] r0, input logic [DATA_W-1:0] r1);
    logic [1:0] rdy;
    ch_valid           = v;
    ch_is_dest_special = sp;
    ch_dest_register   = {d1, d0};
    ch_result          = {r1, r0};
    rdy = ch_ready;
    @(posedge clk);
    if (!flush && reset) begin
      if (v[0] && rdy[0] && qual(sp[0], d0)) exp_q0.push_back({d0, r0});
      if (v[1] && rdy[1] && qual(sp[1], d1)) exp_q1.push_back({d1, r1});
    end
    last_acc = v & rdy;
    @(negedge clk);
    ch_valid = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if (portD_enable !== 1'b0 || portD_key !== '0 || portD_value !== '0 || ch_ready !== 2'b11) begin
      errors++;
      $display("FAIL reset_idle: got en=%b key=%0d value=%h ready=%b, required 0/0/0/11",
               portD_enable, portD_key, portD_value, ch_ready);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++)
      drive(2'b11, 2'b00, 5'd9, 5'd10, $urandom, $urandom);
    ch_valid = 2'b11;
    #1;
    reset = 1'b0;
    clear_model();
    #1;
    vectors++;
    if (portD_enable !== 1'b0 || portD_key !== '0 || portD_value !== '0 || ch_ready !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_traffic: got en=%b key=%0d value=%h ready=%b, required 0/0/0/11",
               portD_enable, portD_key, portD_value, ch_ready);
    end
    ch_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1;
    drive(2'b01, 2'b00, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    vectors++;
    if (portD_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got en=%b after 1 edge, required 0", portD_enable);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (portD_enable !== 1'b1 || portD_key !== 5'd5 || portD_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_latency: got en=%b key=%0d value=%h, required 1/5/deadbeef",
               portD_enable, portD_key, portD_value);
    end
    idle(3);
  endtask

  task automatic test_filter();
    do_reset();
    enable = 1'b1;
    drive(2'b10, 2'b00, 5'd0, 5'd0, 32'h0, 32'h12345678);
    vectors++;
    if (last_acc !== 2'b10) begin
      errors++;
      $display("FAIL filter_handshake: got accepted=%b, required 10", last_acc);
    end
    idle(4);
    drive(2'b10, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1);
    idle(3);
    vectors++;
    if (exp_q1.size() != 0) begin
      errors++;
      $display("FAIL filter_special_x0: got %0d pending, required 0", exp_q1.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] saw_drop;
    do_reset();
    enable   = 1'b1;
    saw_drop = 2'b00;
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, 2'b00, 5'd1, 5'd2, $urandom, $urandom_range(32'hFFFF, 0));
      saw_drop = saw_drop | ~ch_ready;
    end
    idle(8);
    vectors++;
    if (saw_drop !== 2'b11) begin
      errors++;
      $display("FAIL rr_ready_drop: got dropped=%b, required 11", saw_drop);
    end
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: got pending %0d/%0d, required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(2'b11, 2'b00, 5'd3, 5'd4, $urandom, $urandom);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (portD_enable !== 1'b0 || ch_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall_cycle%0d: got en=%b ready=%b, required 0/00", i, portD_enable, ch_ready);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    clear_model();
    drive(2'b11, 2'b00, 5'd7, 5'd8, 32'hCAFE0001, 32'hCAFE0002);
    vectors++;
    if (ch_ready !== 2'b11 || portD_enable !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got ready=%b en=%b, required 11/0", ch_ready, portD_enable);
    end
    flush  = 1'b0;
    enable = 1'b1;
    idle(5);
    drive(2'b01, 2'b00, 5'd11, 5'd0, 32'h0BAD0BAD, 32'h0);
    idle(3);
    vectors++;
    if (exp_q0.size() != 0) begin
      errors++;
      $display("FAIL flush_recover: got %0d pending, required 0", exp_q0.size());
    end
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_single();
    test_filter();
    test_round_robin();
    test_stall_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
